lives_enemy_tracker: RTL
========================

Name: lives_enemy_tracker

Overview:
- Upstream scoring stage for the game state machine: owns player lives and enemy roster, drives the `live[1:0]` and `enemy[1:0]` counts that the FSM compares against zero.
- Consumes one-cycle hit pulses from collision logic; consumes the FSM's `start` and `game` levels to reload and gate play.
- Applies a post-hit invulnerability window.
- Freezes counts once the round is decided, so the FSM sees stable values.

Parameters:
- MAX_LIVES, 3, lives loaded at reset/restart; legal 1..3.
- NUM_ENEMY, 3, enemies per round; legal 1..3.
- INVULN_FRAMES, 60, frames of hit immunity after an accepted hit; 0 disables the window.
- KILLS_PER_LIFE, 2, kills per bonus life (only with BONUS_LIFE_EN).

Ports:
- frame_clk  in  1  frame clock, sole clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  FSM start-screen level; forces reload.
- game  in  1  FSM in-play level; events counted only while high.
- player_hit  in  1  one-cycle pulse: player struck.
- enemy_hit  in  NUM_ENEMY  per-enemy one-cycle kill pulses.
- live  out  2  lives remaining.
- enemy  out  2  enemies alive (popcount of enemy_alive).
- enemy_alive  out  NUM_ENEMY  per-enemy alive flags for the sprite draw.
- invuln  out  1  high during the immunity window; used for sprite blink.

Behaviour:
- All state is updated on posedge frame_clk and all outputs are registered. An event sampled at edge N is visible on outputs after edge N.
- Reset values (Reset high at an edge; overrides all else):
  - live=MAX_LIVES, enemy_alive=all ones, enemy=NUM_ENEMY
  - invuln=0, timer=0, kill counter=0, state=LOAD.
- States: LOAD, PLAY, INVULN, DONE.
- Priority each edge: Reset > start > state logic.
- start high in any state → reload to the reset values, state=LOAD, next edge.
- LOAD:
  - Outputs hold their full values; all events are ignored.
  - game=1 and start=0 → PLAY.
- PLAY, when game=1:
  - Each set bit of enemy_hit whose enemy_alive bit is 1 clears that bit. Kills of already-dead enemies are ignored. Multiple kills in one cycle all apply.
  - enemy is recomputed from the updated enemy_alive in the same edge.
  - player_hit=1 and live>0 → live decrements by 1.
    - If the new live>0 and INVULN_FRAMES>0: invuln=1, timer=INVULN_FRAMES-1, state→INVULN.
- PLAY, when game=0: hold all values and the current state.
- INVULN:
  - player_hit is ignored; enemy kills are still processed.
  - timer decrements each edge. At an edge where timer==0: invuln=0 and state→PLAY.
  - Net effect: invuln is high for exactly INVULN_FRAMES cycles. A hit in the cycle after invuln falls is accepted.
- Round decided (after any update, live==0 or enemy==0) → state DONE, invuln=0.
- Simultaneous last-life hit and last-enemy kill in one cycle: both apply, output is live=0 and enemy=0. The FSM's live-first check resolves this as a loss.
- DONE: all outputs frozen and all events ignored. Exit only via start or Reset.
- Arithmetic:
  - live never underflows; it saturates at 0.
  - enemy never exceeds NUM_ENEMY.
  - Both outputs are zero-extended to 2 bits.

Optional Feature:
- Macro: LIVES_ENEMY_TRACKER_BONUS_LIFE_EN.
- Defined:
  - A 2-bit kill counter increments once per cycle in which at least one accepted kill occurs.
  - On reaching KILLS_PER_LIFE: the counter clears and live increments, saturating at MAX_LIVES. The increment applies at the same edge, after any hit decrement.
  - No bonus is granted on the edge that enters DONE.
  - The counter clears on reload.
- Undefined: no kill counter, and live never increases during a round.

Test Plan:
1. Reset high 1 cycle → live=3, enemy=3, enemy_alive=3'b111, invuln=0. Then start=0, game=1 → PLAY after 1 edge.
2. In PLAY, pulse player_hit at cycle 10 → live=2 and invuln=1 for cycles 11..70 (60 cycles). Hits at cycles 30 and 70 are ignored. A hit at cycle 71 → live=1.
3. Pulse enemy_hit=3'b101 once, then 3'b001 → enemy=1, enemy_alive=3'b010 (repeat kill ignored). Pulse 3'b010 → enemy=0, state DONE. A later player_hit leaves live unchanged.
4. live=1, enemy=1: pulse player_hit with the last enemy_hit in the same cycle → live=0, enemy=0, DONE. Pulse start → next edge live=3, enemy=3, LOAD.
5. game=0 while in PLAY, pulse player_hit and enemy_hit=3'b111 → no change. Assert Reset during INVULN → invuln=0 and full reload on the next edge.
6. With BONUS_LIFE_EN, live=2: kill 2 enemies on separate cycles → live=3. With live=3, a further kill pair leaves live at 3 (saturation).

Source files
------------

// File: rtl/lives_enemy_tracker.sv
// lives_enemy_tracker: player lives / enemy roster bookkeeping for the game FSM.
// Counts are updated on frame_clk, with a post-hit immunity window, and frozen
// once the round is decided.
// Optional bonus-life feature: define LIVES_ENEMY_TRACKER_BONUS_LIFE_EN.
module lives_enemy_tracker #(
  parameter int MAX_LIVES      = 3,
  parameter int NUM_ENEMY      = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int KILLS_PER_LIFE = 2
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 game,
  input  logic                 player_hit,
  input  logic [NUM_ENEMY-1:0] enemy_hit,
  output logic [1:0]           live,
  output logic [1:0]           enemy,
  output logic [NUM_ENEMY-1:0] enemy_alive,
  output logic                 invuln
);

  localparam int TW = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [1:0]    LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [1:0]    ENEMY_INIT = 2'(NUM_ENEMY);
  localparam logic [TW-1:0] TIMER_LOAD = TW'((INVULN_FRAMES > 0) ? INVULN_FRAMES - 1 : 0);

  // Reject illegal configurations at elaboration.
  if (MAX_LIVES < 1 || MAX_LIVES > 3 || NUM_ENEMY < 1 || NUM_ENEMY > 3 ||
      INVULN_FRAMES < 0 || KILLS_PER_LIFE < 1 || KILLS_PER_LIFE > 3) begin : g_bad_param
    $error("lives_enemy_tracker: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_LOAD,
    S_PLAY,
    S_INVULN,
    S_DONE
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [1:0]             r_live,   w_live_nxt;
  logic [1:0]             r_enemy,  w_enemy_nxt;
  logic [NUM_ENEMY-1:0]   r_alive,  w_alive_nxt;
  logic                   r_invuln, w_invuln_nxt;
  logic [TW-1:0]          r_timer,  w_timer_nxt;
  logic                   w_decided;
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
  logic [1:0]             r_kills,  w_kills_nxt;
  logic [NUM_ENEMY-1:0]   w_kill_mask;
`endif

  function automatic logic [1:0] popcount(input logic [NUM_ENEMY-1:0] v);
    logic [1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
      cnt = cnt + 2'(v[i]);
    end
    return cnt;
  endfunction

  // State register: reset loads the full roster, otherwise take next values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state  <= S_LOAD;
      r_live   <= LIVES_INIT;
      r_enemy  <= ENEMY_INIT;
      r_alive  <= '1;
      r_invuln <= 1'b0;
      r_timer  <= '0;
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
      r_kills  <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_live   <= w_live_nxt;
      r_enemy  <= w_enemy_nxt;
      r_alive  <= w_alive_nxt;
      r_invuln <= w_invuln_nxt;
      r_timer  <= w_timer_nxt;
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
      r_kills  <= w_kills_nxt;
`endif
    end
  end

  // Next-state logic: start reload, hit/kill accounting, immunity timer, freeze.
  always_comb begin
    w_state_nxt  = r_state;
    w_live_nxt   = r_live;
    w_alive_nxt  = r_alive;
    w_invuln_nxt = r_invuln;
    w_timer_nxt  = r_timer;
    w_decided    = 1'b0;
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
    w_kills_nxt  = r_kills;
    w_kill_mask  = '0;
`endif

    if (start) begin
      w_state_nxt  = S_LOAD;
      w_live_nxt   = LIVES_INIT;
      w_alive_nxt  = '1;
      w_invuln_nxt = 1'b0;
      w_timer_nxt  = '0;
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
      w_kills_nxt  = '0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (game) w_state_nxt = S_PLAY;
        end
        S_PLAY, S_INVULN: begin
          // The immunity window runs on frames, independent of the game level.
          if (r_state == S_INVULN) begin
            if (r_timer == '0) begin
              w_invuln_nxt = 1'b0;
              w_state_nxt  = S_PLAY;
            end else begin
              w_timer_nxt = r_timer - 1'b1;
            end
          end
          if (game) begin
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
            w_kill_mask = enemy_hit & r_alive;
`endif
            w_alive_nxt = r_alive & ~enemy_hit;
            if (r_state == S_PLAY && player_hit && r_live != '0) begin
              w_live_nxt = r_live - 2'd1;
              if (w_live_nxt != '0 && INVULN_FRAMES > 0) begin
                w_invuln_nxt = 1'b1;
                w_timer_nxt  = TIMER_LOAD;
                w_state_nxt  = S_INVULN;
              end
            end
            // Decided is judged before any bonus so the entering edge never grants one.
            w_decided = (w_live_nxt == '0) || (popcount(w_alive_nxt) == '0);
            if (w_decided) begin
              w_state_nxt  = S_DONE;
              w_invuln_nxt = 1'b0;
              w_timer_nxt  = '0;
            end
`ifdef LIVES_ENEMY_TRACKER_BONUS_LIFE_EN
            else if (|w_kill_mask) begin
              if (32'(r_kills) + 1 == KILLS_PER_LIFE) begin
                w_kills_nxt = '0;
                if (w_live_nxt < LIVES_INIT) w_live_nxt = w_live_nxt + 2'd1;
              end else begin
                w_kills_nxt = r_kills + 2'd1;
              end
            end
`endif
          end
        end
        default: ;  // S_DONE: frozen until start or Reset
      endcase
    end
    w_enemy_nxt = popcount(w_alive_nxt);
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    live        = r_live;
    enemy       = r_enemy;
    enemy_alive = r_alive;
    invuln      = r_invuln;
  end

endmodule
